// File: rtl/switch_port_scheduler.sv
// rtl/switch_port_scheduler.sv - frame-granular weighted round-robin grant for one output port
module switch_port_scheduler #(
  parameter int RADIX       = 4,
  parameter int QUOTA_WIDTH = 4,
  parameter int SEL_WIDTH   = $clog2(RADIX)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RADIX-1:0]             req,
  input  logic [RADIX*QUOTA_WIDTH-1:0] cfg_quota,
  output logic [RADIX-1:0]             grant,
  output logic                         grant_valid,
  output logic [SEL_WIDTH-1:0]         grant_encoded,
  input  logic                         beat_ack,
  input  logic                         beat_last
);

  typedef enum logic {ARB, GRANT} state_t;

  state_t                 state, state_next;
  logic [SEL_WIDTH-1:0]   ptr, ptr_next;
  logic [SEL_WIDTH-1:0]   cur, cur_next, cur_inc;
  logic [QUOTA_WIDTH-1:0] quota_rem, quota_next;
  logic [QUOTA_WIDTH-1:0] cfg_sel, quota_load;
  logic [SEL_WIDTH-1:0]   scan_idx, winner;
  logic                   scan_found, keep_cur;
  int                     scan_pos;

  logic [RADIX-1:0]       grant_next;
  logic                   grant_valid_next;
  logic [SEL_WIDTH-1:0]   grant_encoded_next;

  // Round-robin scan starting at ptr; the current holder wins outright while it has quota left.
  always_comb begin
    scan_idx   = '0;
    scan_found = 1'b0;
    scan_pos   = 0;
    for (int i = 0; i < RADIX; i++) begin
      scan_pos = (int'(ptr) + i) % RADIX;
      if (!scan_found && req[scan_pos]) begin
        scan_found = 1'b1;
        scan_idx   = SEL_WIDTH'(scan_pos);
      end
    end
    keep_cur   = req[cur] && (quota_rem != '0);
    winner     = keep_cur ? cur : scan_idx;
    cfg_sel    = cfg_quota[int'(winner)*QUOTA_WIDTH +: QUOTA_WIDTH];
    quota_load = (cfg_sel == '0) ? QUOTA_WIDTH'(1) : cfg_sel;
    cur_inc    = (cur == SEL_WIDTH'(RADIX-1)) ? '0 : cur + SEL_WIDTH'(1);
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cur_next   = cur;
    quota_next = quota_rem;
    case (state)
      ARB: begin
        if (|req) begin
          state_next = GRANT;
          cur_next   = winner;
          if (winner != cur || quota_rem == '0)
            quota_next = quota_load;
        end
      end
      GRANT: begin
        if (beat_ack && beat_last) begin
          state_next = ARB;
          quota_next = quota_rem - QUOTA_WIDTH'(1);
          if (quota_rem == QUOTA_WIDTH'(1))
            ptr_next = cur_inc;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Outputs are registered copies of what the next state implies, so the gap after a release is one cycle.
  always_comb begin
    grant_next         = '0;
    grant_valid_next   = 1'b0;
    grant_encoded_next = '0;
    if (state_next == GRANT) begin
      grant_next         = {{(RADIX-1){1'b0}}, 1'b1} << cur_next;
      grant_valid_next   = 1'b1;
      grant_encoded_next = cur_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB;
      ptr           <= '0;
      cur           <= '0;
      quota_rem     <= '0;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
    end else begin
      state         <= state_next;
      ptr           <= ptr_next;
      cur           <= cur_next;
      quota_rem     <= quota_next;
      grant         <= grant_next;
      grant_valid   <= grant_valid_next;
      grant_encoded <= grant_encoded_next;
    end
  end

endmodule
